// File: rtl/fifo_pack_pkg.sv
// Shared types and helpers for the FIFO read-side word packer.
// Default configuration: 8-bit FIFO words packed four to an output word.
package fifo_pack_pkg;

    localparam int unsigned DEF_DSIZE   = 8;
    localparam int unsigned DEF_PACK    = 4;
    localparam int unsigned DEF_IDX_W   = $clog2(DEF_PACK);
    localparam int unsigned DEF_LANES_W = $clog2(DEF_PACK + 1);

    typedef logic [DEF_IDX_W-1:0]   lane_idx_t;
    typedef logic [DEF_LANES_W-1:0] lanes_t;

    // FILL: accumulating words; PEND: a flushed partial word waits for the out slot
    typedef enum logic {
        FILL = 1'b0,
        PEND = 1'b1
    } flush_state_e;

    // Bit offset of pop-order lane i inside the packed output word
    function automatic int unsigned place_lane(input int unsigned i,
                                               input bit          msb_first,
                                               input int unsigned pack  = DEF_PACK,
                                               input int unsigned dsize = DEF_DSIZE);
        return msb_first ? (pack - 1 - i) * dsize : i * dsize;
    endfunction

endpackage

// File: rtl/fifo_rd_word_packer_if.sv
// FIFO read handshake plus packed-word valid/ready output bundle.
// master: the packer; slave: the FIFO and downstream sink side.
interface fifo_rd_word_packer_if
    import fifo_pack_pkg::*;
#(
    parameter int unsigned DSIZE = DEF_DSIZE,
    parameter int unsigned PACK  = DEF_PACK
);
    localparam int unsigned LANES_W = $clog2(PACK + 1);

    logic                  rempty;
    logic [DSIZE-1:0]      rdata;
    logic                  rinc;
    logic                  flush;
    logic [DSIZE*PACK-1:0] out_data;
    logic [LANES_W-1:0]    out_lanes;
    logic                  out_last;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        input  rempty, rdata, flush, out_ready,
        output rinc, out_data, out_lanes, out_last, out_valid
    );

    modport slave (
        output rempty, rdata, flush, out_ready,
        input  rinc, out_data, out_lanes, out_last, out_valid
    );

endinterface

// File: rtl/fifo_pack_lane_acc.sv
// Lane register file holding lanes 0..PACK-2 of the word being assembled.
// One lane is written per pop, selected by the current lane index.
module fifo_pack_lane_acc #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned PACK  = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [IDX_W-1:0] widx_i,
    input  logic [DSIZE-1:0] wdata_i,
    output logic [DSIZE-1:0] acc_o [PACK-1]
);

    for (genvar g = 0; g < PACK - 1; g++) begin : g_lane
        logic [DSIZE-1:0] lane_q;

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                lane_q <= '0;
            end else if (we_i && (widx_i == IDX_W'(g))) begin
                lane_q <= wdata_i;
            end
        end

        assign acc_o[g] = lane_q;
    end

endmodule

// File: rtl/fifo_rd_word_packer.sv
// Read-domain FIFO consumer: pops DSIZE-bit words, packs PACK of them into one
// wide word and hands it downstream on valid/ready; flush emits a partial word.
module fifo_rd_word_packer
    import fifo_pack_pkg::*;
#(
    parameter int unsigned DSIZE     = DEF_DSIZE,
    parameter int unsigned PACK      = DEF_PACK,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                    rclk,
    input  logic                    rrst_n,
    fifo_rd_word_packer_if.master   bus
);

    localparam int unsigned IDX_W   = $clog2(PACK);
    localparam int unsigned LANES_W = $clog2(PACK + 1);
    localparam int unsigned OUT_W   = DSIZE * PACK;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACK - 1);

    flush_state_e        state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [OUT_W-1:0]    out_data_q, out_data_d;
    logic [LANES_W-1:0]  out_lanes_q, out_lanes_d;
    logic                out_last_q, out_last_d;
    logic                out_valid_q, out_valid_d;

    logic                slot_free_c;
    logic                rinc_c;
    logic                acc_we_c;
    logic [DSIZE-1:0]    acc_w  [PACK-1];
    logic [DSIZE-1:0]    lane_w [PACK];
    logic [OUT_W-1:0]    full_word_c;
    logic [OUT_W-1:0]    part_word_c;

    // Slot can take a new word if empty or being drained this cycle
    assign slot_free_c = !out_valid_q || bus.out_ready;
    assign rinc_c      = rrst_n && !bus.rempty && (state_q == FILL)
                         && ((idx_q != LAST_IDX) || slot_free_c);
    assign acc_we_c    = rinc_c && (idx_q != LAST_IDX);

    fifo_pack_lane_acc #(
        .DSIZE (DSIZE),
        .PACK  (PACK),
        .IDX_W (IDX_W)
    ) u_lane_acc (
        .clk_i   (rclk),
        .rst_ni  (rrst_n),
        .we_i    (acc_we_c),
        .widx_i  (idx_q),
        .wdata_i (bus.rdata),
        .acc_o   (acc_w)
    );

    for (genvar g = 0; g < PACK - 1; g++) begin : g_gather
        assign lane_w[g] = acc_w[g];
    end
    assign lane_w[PACK-1] = bus.rdata;

    // Full word includes the head FIFO word; partial word masks lanes >= idx
    always_comb begin
        full_word_c = '0;
        part_word_c = '0;
        for (int unsigned i = 0; i < PACK; i++) begin
            full_word_c[place_lane(i, MSB_FIRST, PACK, DSIZE) +: DSIZE] = lane_w[i[IDX_W-1:0]];
            if (i < 32'(idx_q)) begin
                part_word_c[place_lane(i, MSB_FIRST, PACK, DSIZE) +: DSIZE] = lane_w[i[IDX_W-1:0]];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_lanes_d = out_lanes_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            FILL: begin
                if (rinc_c) begin
                    if (idx_q == LAST_IDX) begin
                        out_data_d  = full_word_c;
                        out_lanes_d = LANES_W'(PACK);
                        out_last_d  = bus.flush;
                        out_valid_d = 1'b1;
                        idx_d       = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                if (bus.flush && (idx_d != '0)) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (slot_free_c) begin
                    out_data_d  = part_word_c;
                    out_lanes_d = LANES_W'(idx_q);
                    out_last_d  = 1'b1;
                    out_valid_d = 1'b1;
                    idx_d       = '0;
                    state_d     = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            idx_q       <= '0;
            out_data_q  <= '0;
            out_lanes_q <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_lanes_q <= out_lanes_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.rinc      = rinc_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_lanes = out_lanes_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_fifo_rd_word_packer.sv
// Directed bench for fifo_rd_word_packer (DSIZE=8, PACK=4, LSB-first) with a
// queue-backed FIFO model and a scoreboard of expected output words.
module tb_fifo_rd_word_packer;
    import fifo_pack_pkg::*;

    localparam int unsigned DSIZE = 8;
    localparam int unsigned PACK  = 4;

    typedef struct packed {
        logic [31:0] data;
        lanes_t      lanes;
        logic        last;
    } exp_t;

    logic rclk = 1'b0;
    logic rrst_n;

    fifo_rd_word_packer_if #(.DSIZE(DSIZE), .PACK(PACK)) bus ();

    fifo_rd_word_packer #(
        .DSIZE     (DSIZE),
        .PACK      (PACK),
        .MSB_FIRST (1'b0)
    ) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus)
    );

    always #5 rclk = ~rclk;

    logic [7:0] fifo_q [$];
    exp_t       exp_q  [$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         pop_cnt = 0;
    logic       last_pop = 1'b0;
    bit         hold_empty = 1'b0;
    bit         pulse_empty = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        bus.rempty = hold_empty || (fifo_q.size() == 0);
        bus.rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic push_exp(input logic [31:0] d, input int unsigned n, input logic l);
        exp_t e;
        e.data  = d;
        e.lanes = lanes_t'(n);
        e.last  = l;
        exp_q.push_back(e);
    endtask

    // One clock: sample at negedge, advance FIFO model just after posedge
    task automatic cycle();
        exp_t e;
        @(negedge rclk);
        last_pop = bus.rinc;
        if (!rrst_n) chk("rst_rinc", 64'(bus.rinc), 64'(0));
        if (bus.rempty) chk("empty_rinc", 64'(bus.rinc), 64'(0));
        if (rrst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", 64'(bus.out_valid), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("out_data", 64'(bus.out_data), 64'(e.data));
                chk("out_lanes", 64'(bus.out_lanes), 64'(e.lanes));
                chk("out_last", 64'(bus.out_last), 64'(e.last));
            end
        end
        if (last_pop) pop_cnt++;
        @(posedge rclk);
        #1;
        if (last_pop && (fifo_q.size() != 0)) void'(fifo_q.pop_front());
        bus.flush  = 1'b0;
        hold_empty = pulse_empty ? !hold_empty : 1'b0;
        refresh();
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) cycle();
        chk("drain_left", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic push_words(input logic [7:0] first, input int unsigned n, input logic [7:0] step);
        logic [7:0] v;
        v = first;
        for (int unsigned k = 0; k < n; k++) begin
            fifo_q.push_back(v);
            v = v + step;
        end
        refresh();
    endtask

    initial begin
        rrst_n        = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        fifo_q.push_back(8'hEE);
        refresh();

        // Reset with data available
        repeat (3) cycle();
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_out_data", 64'(bus.out_data), 64'(0));
        chk("rst_out_lanes", 64'(bus.out_lanes), 64'(0));
        fifo_q.delete();
        rrst_n = 1'b1;
        refresh();

        // Streaming
        bus.out_ready = 1'b1;
        push_words(8'h11, 8, 8'h11);
        push_exp(32'h44332211, 4, 1'b0);
        push_exp(32'h88776655, 4, 1'b0);
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("stream_rinc", 64'(last_pop), 64'(1));
        end
        drain();

        // Back-pressure
        bus.out_ready = 1'b0;
        push_words(8'h11, 8, 8'h11);
        pop_cnt = 0;
        repeat (12) cycle();
        chk("bp_pops", 64'(pop_cnt), 64'(7));
        chk("bp_idx", 64'(dut.idx_q), 64'(3));
        chk("bp_stall_rinc", 64'(bus.rinc), 64'(0));
        push_exp(32'h44332211, 4, 1'b0);
        push_exp(32'h88776655, 4, 1'b0);
        bus.out_ready = 1'b1;
        cycle();
        chk("bp_pop_on_xfer", 64'(last_pop), 64'(1));
        drain();

        // Flush partial while the out slot is held
        bus.out_ready = 1'b0;
        push_words(8'h01, 4, 8'h01);
        fifo_q.push_back(8'hA1);
        fifo_q.push_back(8'hB2);
        fifo_q.push_back(8'hC3);
        refresh();
        for (int k = 0; k < 20 && !(fifo_q.size() != 0 && fifo_q[0] == 8'hB2); k++) cycle();
        bus.flush = 1'b1;
        cycle();
        chk("flush_with_pop", 64'(last_pop), 64'(1));
        pop_cnt = 0;
        repeat (5) cycle();
        chk("pend_no_pop", 64'(pop_cnt), 64'(0));
        push_exp(32'h04030201, 4, 1'b0);
        push_exp(32'h0000B2A1, 2, 1'b1);
        bus.out_ready = 1'b1;
        drain();

        // Flush a single-lane partial, then flush with nothing accumulated
        push_exp(32'h000000C3, 1, 1'b1);
        bus.flush = 1'b1;
        drain();
        bus.flush = 1'b1;
        repeat (6) cycle();
        chk("idle_flush_valid", 64'(bus.out_valid), 64'(0));
        chk("idle_flush_idx", 64'(dut.idx_q), 64'(0));

        // Flush coincident with the completing pop
        push_words(8'h21, 4, 8'h01);
        push_exp(32'h24232221, 4, 1'b1);
        for (int k = 0; k < 20 && !(fifo_q.size() != 0 && fifo_q[0] == 8'h24); k++) cycle();
        bus.flush = 1'b1;
        cycle();
        chk("flush_full_pop", 64'(last_pop), 64'(1));
        drain();
        repeat (6) cycle();
        chk("no_extra_word", 64'(bus.out_valid), 64'(0));

        // Reset mid-fill, then refill under rempty pulses
        push_words(8'h31, 3, 8'h01);
        for (int k = 0; k < 10 && fifo_q.size() != 0; k++) cycle();
        rrst_n = 1'b0;
        cycle();
        rrst_n = 1'b1;
        pulse_empty = 1'b1;
        hold_empty  = 1'b1;
        push_words(8'h01, 4, 8'h01);
        push_exp(32'h04030201, 4, 1'b0);
        drain();
        pulse_empty = 1'b0;
        repeat (4) cycle();
        chk("final_idle_valid", 64'(bus.out_valid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
